// File: rtl/ysyx_ifu_fetch.sv
// Instruction fetch unit: takes a PC, performs one outstanding word read on the
// instruction-memory port, and hands {inst, inst_pc, inst_fault} to decode.
module ysyx_ifu_fetch #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [1:0]        inst_fault,
  input  logic              inst_ready
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_BUS      = 2'b10;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state, state_d;

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              mem_req_valid_d;
  logic              inst_valid_d;
  logic [ADDR_W-1:0] mem_req_addr_d;
  logic [ADDR_W-1:0] inst_pc_d;
  logic [31:0]       inst_d;
  logic [1:0]        inst_fault_d;

  logic pc_fire;
  logic pc_misaligned;
  logic timeout_hit;

  // A new PC is taken in IDLE, or in HOLD when the held instruction leaves
  // this same cycle and is not being flushed.
  assign pc_ready      = (state == S_IDLE) ||
                         ((state == S_HOLD) && inst_ready && !flush);
  assign pc_fire       = pc_valid && pc_ready;
  assign pc_misaligned = (pc_i[1:0] != 2'b00);
  assign timeout_hit   = (cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (pc_fire) begin
          state_d = pc_misaligned ? S_HOLD : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // A flush with the response arriving the same cycle owes nothing more.
        if (flush) begin
          state_d = mem_rsp_valid ? S_IDLE : S_DRAIN;
        end else if (mem_rsp_valid || timeout_hit) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (inst_ready) begin
          if (pc_fire) begin
            state_d = pc_misaligned ? S_HOLD : S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (mem_rsp_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and the wait counter
  always_comb begin
    mem_req_valid_d = (state_d == S_REQ);
    inst_valid_d    = (state_d == S_HOLD);
    mem_req_addr_d  = mem_req_addr;
    inst_pc_d       = inst_pc;
    inst_d          = NOP_INST;
    inst_fault_d    = FLT_NONE;
    cnt_d           = '0;

    if (pc_fire && !pc_misaligned) begin
      mem_req_addr_d = {pc_i[ADDR_W-1:2], 2'b00};
    end

    if ((state == S_WAIT) && (state_d == S_WAIT)) begin
      cnt_d = cnt + CNT_W'(1);
    end

    if (state_d == S_HOLD) begin
      if (pc_fire) begin
        inst_pc_d    = pc_i;
        inst_fault_d = FLT_MISALIGN;
      end else if (state == S_WAIT) begin
        inst_pc_d = mem_req_addr;
        if (!mem_rsp_valid) begin
          inst_fault_d = FLT_TIMEOUT;
        end else if (mem_rsp_err) begin
          inst_fault_d = FLT_BUS;
        end else begin
          inst_d = mem_rsp_data;
        end
      end else begin
        inst_d       = inst;
        inst_fault_d = inst_fault;
      end
    end
  end

  // Output and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      inst_valid    <= 1'b0;
      inst          <= NOP_INST;
      inst_pc       <= '0;
      inst_fault    <= FLT_NONE;
      cnt           <= '0;
    end else begin
      mem_req_valid <= mem_req_valid_d;
      mem_req_addr  <= mem_req_addr_d;
      inst_valid    <= inst_valid_d;
      inst          <= inst_d;
      inst_pc       <= inst_pc_d;
      inst_fault    <= inst_fault_d;
      cnt           <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_fetch.sv
// Bench for ysyx_ifu_fetch: behavioural instruction memory plus a scoreboard of
// expected {inst, pc, fault} popped whenever decode consumes an instruction.
module tb_ysyx_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_fault;
  logic        inst_ready = 1'b0;

  ysyx_ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid      (pc_valid),
    .pc_ready      (pc_ready),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_fault    (inst_fault),
    .inst_ready    (inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Memory model knobs
  int          mem_lat = 0;
  logic        mem_err_mode = 1'b0;
  logic        mem_mute = 1'b0;
  int          req_count = 0;
  logic        pending = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a ^ 32'h5A5A_0003;
  endfunction

  // Memory: response mem_lat cycles after the earliest (zero-wait) slot
  always @(posedge clk) begin
    mem_rsp_valid <= 1'b0;
    mem_rsp_err   <= 1'b0;
    mem_rsp_data  <= '0;
    if (rst) begin
      pending <= 1'b0;
    end else if (mem_req_valid && mem_req_ready) begin
      req_count <= req_count + 1;
      if (!mem_mute) begin
        if (mem_lat == 0) begin
          mem_rsp_valid <= 1'b1;
          mem_rsp_err   <= mem_err_mode;
          mem_rsp_data  <= mem_err_mode ? 32'hDEAD_BEEF : mem_word(mem_req_addr);
        end else begin
          pending   <= 1'b1;
          lat_cnt   <= mem_lat - 1;
          pend_addr <= mem_req_addr;
        end
      end
    end else if (pending) begin
      if (lat_cnt == 0) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_err   <= mem_err_mode;
        mem_rsp_data  <= mem_err_mode ? 32'hDEAD_BEEF : mem_word(pend_addr);
        pending       <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // Scoreboard consumer and idle-NOP monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_valid && inst_ready && !flush) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got inst=%h pc=%h fault=%b, required no instruction",
                   inst, inst_pc, inst_fault);
        end else begin
          mon_e = sb.pop_front();
          if (inst !== mon_e.inst || inst_pc !== mon_e.pc || inst_fault !== mon_e.fault) begin
            errors++;
            $display("FAIL sb_inst: got inst=%h pc=%h fault=%b, required inst=%h pc=%h fault=%b",
                     inst, inst_pc, inst_fault, mon_e.inst, mon_e.pc, mon_e.fault);
          end
        end
      end
      if (!inst_valid) begin
        checks++;
        if (inst !== NOP) begin
          errors++;
          $display("FAIL idle_nop: got inst=%h, required %h", inst, NOP);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until inst_valid; lat is the cycle count (0 if budget expired)
  task automatic wait_inst(input int budget, output int lat, output int req_at);
    lat    = 0;
    req_at = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      pc_valid = 1'b0;
      if (mem_req_valid && req_at == 0) req_at = c;
      if (inst_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc_ready !== 1'b1) begin
      errors++; $display("FAIL reset_pc_ready: got %b required 1", pc_ready);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valids: got req=%b inst=%b required 0 0", mem_req_valid, inst_valid);
    end
    checks++;
    if (inst !== NOP || inst_fault !== 2'b00) begin
      errors++; $display("FAIL reset_inst: got inst=%h fault=%b required %h 00", inst, inst_fault, NOP);
    end
    checks++;
    if (inst_pc !== 32'h0 || mem_req_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got inst_pc=%h addr=%h required 0 0", inst_pc, mem_req_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, req_at;
    mem_lat = 0;
    pc_i = 32'h8000_0000;
    pc_valid = 1'b1;
    sb.push_back('{inst: 32'h0010_0093, pc: 32'h8000_0000, fault: 2'b00});
    wait_inst(20, lat, req_at);
    checks++;
    if (req_at !== 1) begin
      errors++; $display("FAIL basic_req_latency: got %0d required 1", req_at);
    end
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL basic_inst_latency: got %0d required 3", lat);
    end
    checks++;
    if (mem_req_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL basic_req_addr: got %h required 80000000", mem_req_addr);
    end
    checks++;
    if (inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0000 || inst_fault !== 2'b00) begin
      errors++; $display("FAIL basic_inst: got %h/%h/%b required 00100093/80000000/00", inst, inst_pc, inst_fault);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0000) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b inst=%h pc=%h required 1/00100093/80000000",
                 i, inst_valid, inst, inst_pc);
      end
    end
    consume();
    checks++;
    if (inst_valid !== 1'b0 || inst !== NOP || inst_fault !== 2'b00) begin
      errors++; $display("FAIL stall_release: got v=%b inst=%h fault=%b required 0/%h/00", inst_valid, inst, inst_fault, NOP);
    end
  endtask

  task automatic test_misaligned();
    int lat, req_at, rc0;
    rc0 = req_count;
    pc_i = 32'h8000_0002;
    pc_valid = 1'b1;
    sb.push_back('{inst: NOP, pc: 32'h8000_0002, fault: 2'b01});
    wait_inst(10, lat, req_at);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL misalign_latency: got %0d required 1", lat);
    end
    checks++;
    if (req_at !== 0 || req_count !== rc0) begin
      errors++; $display("FAIL misalign_no_bus: got req_at=%0d reqs=%0d required 0 %0d", req_at, req_count, rc0);
    end
    checks++;
    if (inst !== NOP || inst_fault !== 2'b01) begin
      errors++; $display("FAIL misalign_inst: got %h/%b required %h/01", inst, inst_fault, NOP);
    end
    consume();
  endtask

  task automatic test_flush_drain();
    int lat, req_at;
    logic saw_valid;
    mem_lat = 4;
    pc_i = 32'h8000_0010;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (pc_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL drain_busy: got pc_ready=%b req=%b required 0 0", pc_ready, mem_req_valid);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (inst_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++; $display("FAIL drain_discard: got inst_valid seen=%b required 0", saw_valid);
    end
    checks++;
    if (pc_ready !== 1'b1) begin
      errors++; $display("FAIL drain_idle: got pc_ready=%b required 1", pc_ready);
    end
    mem_lat = 0;
    pc_i = 32'h8000_0020;
    pc_valid = 1'b1;
    sb.push_back('{inst: mem_word(32'h8000_0020), pc: 32'h8000_0020, fault: 2'b00});
    wait_inst(20, lat, req_at);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL drain_next_latency: got %0d required 3", lat);
    end
    consume();
  endtask

  task automatic test_bus_err();
    int lat, req_at;
    mem_err_mode = 1'b1;
    pc_i = 32'h8000_0030;
    pc_valid = 1'b1;
    sb.push_back('{inst: NOP, pc: 32'h8000_0030, fault: 2'b10});
    wait_inst(20, lat, req_at);
    checks++;
    if (lat !== 3 || inst_fault !== 2'b10 || inst !== NOP) begin
      errors++; $display("FAIL bus_err: got lat=%0d fault=%b inst=%h required 3/10/%h", lat, inst_fault, inst, NOP);
    end
    consume();
    mem_err_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int lat, req_at;
    mem_mute = 1'b1;
    pc_i = 32'h8000_0040;
    pc_valid = 1'b1;
    sb.push_back('{inst: NOP, pc: 32'h8000_0040, fault: 2'b11});
    wait_inst(300, lat, req_at);
    checks++;
    if (lat < 257 || lat > 258) begin
      errors++; $display("FAIL timeout_latency: got %0d required 257..258", lat);
    end
    checks++;
    if (inst_fault !== 2'b11 || inst !== NOP) begin
      errors++; $display("FAIL timeout_fault: got fault=%b inst=%h required 11/%h", inst_fault, inst, NOP);
    end
    consume();
    mem_mute = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    int idx;
    logic fire;
    pcs = '{32'h8000_0100, 32'h8000_0104, 32'h8000_0106, 32'h8000_0108};
    mem_lat = 0;
    inst_ready = 1'b1;
    idx = 0;
    pc_i = pcs[0];
    pc_valid = 1'b1;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      fire = pc_valid && pc_ready;
      if (fire) begin
        if (pcs[idx][1:0] != 2'b00)
          sb.push_back('{inst: NOP, pc: pcs[idx], fault: 2'b01});
        else
          sb.push_back('{inst: mem_word(pcs[idx]), pc: pcs[idx], fault: 2'b00});
      end
      tick();
      if (fire) begin
        idx++;
        if (idx < 4) pc_i = pcs[idx];
        else pc_valid = 1'b0;
      end
    end
    checks++;
    if (idx !== 4) begin
      errors++; $display("FAIL b2b_accept: got %0d accepted required 4", idx);
    end
    for (int c = 0; c < 20 && sb.size() > 0; c++) tick();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL b2b_drain: got %0d pending required 0", sb.size());
    end
    inst_ready = 1'b0;
    pc_valid = 1'b0;
  endtask

  task automatic test_flush_hold();
    int lat, req_at;
    mem_lat = 0;
    pc_i = 32'h8000_0050;
    pc_valid = 1'b1;
    wait_inst(20, lat, req_at);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL flush_hold_setup: got %0d required 3", lat);
    end
    flush = 1'b1;
    inst_ready = 1'b1;
    pc_valid = 1'b1;
    pc_i = 32'h8000_0060;
    #1;
    checks++;
    if (pc_ready !== 1'b0) begin
      errors++; $display("FAIL flush_hold_pc_ready: got %b required 0", pc_ready);
    end
    tick();
    flush = 1'b0;
    inst_ready = 1'b0;
    pc_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL flush_hold_drop: got v=%b req=%b required 0 0", inst_valid, mem_req_valid);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int lat, req_at;
    mem_lat = 10;
    pc_i = 32'h8000_0070;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc_ready !== 1'b1) begin
      errors++; $display("FAIL async_rst_ctrl: got req=%b v=%b pc_ready=%b required 0 0 1", mem_req_valid, inst_valid, pc_ready);
    end
    checks++;
    if (inst !== NOP || inst_pc !== 32'h0 || inst_fault !== 2'b00 || mem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_rst_data: got inst=%h pc=%h fault=%b addr=%h required %h 0 00 0",
               inst, inst_pc, inst_fault, mem_req_addr, NOP);
    end
    tick();
    rst = 1'b0;
    tick();
    mem_lat = 0;
    pc_i = 32'h8000_0080;
    pc_valid = 1'b1;
    sb.push_back('{inst: mem_word(32'h8000_0080), pc: 32'h8000_0080, fault: 2'b00});
    wait_inst(20, lat, req_at);
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL post_rst_latency: got %0d required 3", lat);
    end
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_misaligned();
    test_flush_drain();
    test_bus_err();
    test_timeout();
    test_back_to_back();
    test_flush_hold();
    test_async_reset();
    tick();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
